// File: rtl/instr_encoder_if.sv
// Instruction-type package and the field-side / word-side handshake interface for instr_encoder.
package instr_encoder_pkg;
    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_J = 3'd4,
        TYPE_U = 3'd5
    } instr_type_enum;
endpackage

interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic           in_valid;
    logic           in_ready;
    instr_type_enum instr_type_enum_inst;
    logic [6:0]     opcode;
    logic [4:0]     rd;
    logic [2:0]     funct3;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [6:0]     funct7;
    logic [31:0]    imm;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    Instr;
    logic [31:0]    addr;

    modport master (
        output in_valid, instr_type_enum_inst, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
        input  in_ready, out_valid, Instr, addr
    );

    modport slave (
        input  in_valid, instr_type_enum_inst, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
        output in_ready, out_valid, Instr, addr
    );
endinterface

// File: rtl/instr_encoder.sv
// RISC-V field-to-word encoder with address tagging and an output FIFO.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    instr_encoder_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int unsigned       PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL  = DEPTH[PTR_W:0];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      next_addr;
    logic [31:0]      word;
    logic             legal;
    logic             accept;
    logic             push;
    logic             pop;

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (bus.instr_type_enum_inst)
            TYPE_R: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            TYPE_I: begin
                word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                legal = (bus.imm[31:11] == {21{bus.imm[11]}});
`endif
            end
            TYPE_S: begin
                word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                legal = (bus.imm[31:11] == {21{bus.imm[11]}});
`endif
            end
            TYPE_B: begin
                word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                legal = (bus.imm[31:12] == {20{bus.imm[12]}}) && !bus.imm[0];
`endif
            end
            TYPE_J: begin
                word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                legal = (bus.imm[31:20] == {12{bus.imm[20]}}) && !bus.imm[0];
`endif
            end
            TYPE_U: begin
                word = {bus.imm[31:12], bus.rd, bus.opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                legal = (bus.imm[11:0] == 12'd0);
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    // Ready depends only on registered occupancy and flush, never on out_ready.
    assign bus.in_ready  = (count != FULL) && !flush;
    assign bus.out_valid = (count != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && legal;
    assign pop           = bus.out_valid && bus.out_ready && !flush;
    assign bus.Instr     = bus.out_valid ? mem[rd_ptr].instr : 32'd0;
    assign bus.addr      = bus.out_valid ? mem[rd_ptr].addr  : BASE_ADDR;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                next_addr <= next_addr + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err <= accept && !legal;
        end
    end

    // NOTE: the payload array is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {word, next_addr};
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: two instances (base 0 and base 0xFFFFFFFC) share stimulus.
`timescale 1ns/1ps
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] BASE_W = 32'hFFFF_FFFC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] count, count_w;
    logic       err, err_w;

    instr_encoder_if bus ();
    instr_encoder_if bus_w ();

    assign bus_w.in_valid             = bus.in_valid;
    assign bus_w.instr_type_enum_inst = bus.instr_type_enum_inst;
    assign bus_w.opcode               = bus.opcode;
    assign bus_w.rd                   = bus.rd;
    assign bus_w.funct3               = bus.funct3;
    assign bus_w.rs1                  = bus.rs1;
    assign bus_w.rs2                  = bus.rs2;
    assign bus_w.funct7               = bus.funct7;
    assign bus_w.imm                  = bus.imm;
    assign bus_w.out_ready            = bus.out_ready;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .count(count), .err(err)
    );
    instr_encoder #(.BASE_ADDR(BASE_W), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_w), .count(count_w), .err(err_w)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] off;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_off;
    bit          m_err;
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference encoding: place each field at its bit offset with shifts and masks.
    function automatic logic [31:0] model_enc(instr_type_enum t, logic [31:0] op, logic [31:0] rd,
                                              logic [31:0] f3, logic [31:0] rs1, logic [31:0] rs2,
                                              logic [31:0] f7, logic [31:0] imm);
        logic [31:0] base = (f3 << 12) | (rs1 << 15) | op;
        case (t)
            TYPE_R:  return base | (f7 << 25) | (rs2 << 20) | (rd << 7);
            TYPE_I:  return base | ((imm & 32'hFFF) << 20) | (rd << 7);
            TYPE_S:  return base | (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((imm & 32'h1F) << 7);
            TYPE_B:  return base | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
            TYPE_U:  return (imm & 32'hFFFF_F000) | (rd << 7) | op;
            TYPE_J:  return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_legal(instr_type_enum t, logic [31:0] imm);
        longint s = longint'($signed(imm));
        if (int'(t) > 5) return 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        case (t)
            TYPE_I, TYPE_S: return (s >= -2048) && (s <= 2047);
            TYPE_B:         return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            TYPE_J:         return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (s % 2 == 0);
            TYPE_U:         return (imm % 4096) == 0;
            default:        return 1'b1;
        endcase
`else
        return (s == s);
`endif
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q.size() != 0) ? q[0].instr : 32'd0;
    endfunction

    function automatic logic [31:0] exp_addr(logic [31:0] b);
        return (q.size() != 0) ? b + q[0].off : b;
    endfunction

    // One clock: the model consumes the inputs present at the edge, then outputs settle.
    task automatic step();
        bit acc, pop;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
            m_off = 32'd0;
            m_err = 1'b0;
        end else begin
            pop   = (q.size() != 0) && bus.out_ready;
            acc   = bus.in_valid && (q.size() != DEPTH);
            m_err = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (model_legal(bus.instr_type_enum_inst, bus.imm)) begin
                    q.push_back('{model_enc(bus.instr_type_enum_inst, 32'(bus.opcode), 32'(bus.rd),
                                            32'(bus.funct3), 32'(bus.rs1), 32'(bus.rs2),
                                            32'(bus.funct7), bus.imm), m_off});
                    m_off += 32'd4;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(instr_type_enum t, logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                         logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7, logic [31:0] imm);
        bus.in_valid             = 1'b1;
        bus.instr_type_enum_inst = t;
        bus.opcode = op; bus.rd = rd; bus.funct3 = f3;
        bus.rs1 = rs1; bus.rs2 = rs2; bus.funct7 = f7; bus.imm = imm;
    endtask

    task automatic drive_legal();
        instr_type_enum t = instr_type_enum'($urandom_range(0, 5));
        logic [31:0] imm;
        case (t)
            TYPE_I, TYPE_S: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            TYPE_B:         imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            TYPE_J:         imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            TYPE_U:         imm = $urandom() & 32'hFFFF_F000;
            default:        imm = $urandom();
        endcase
        drive(t, 7'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()),
              5'($urandom()), 7'($urandom()), imm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (bus.Instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", bus.Instr); end
        n_vec++; if (bus_w.addr !== BASE_W) begin n_bad++; $display("FAIL reset_addr: got %h want %h", bus_w.addr, BASE_W); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single_r();
        drive(TYPE_R, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL r_out_valid: got %b want 1", bus.out_valid); end
        n_vec++; if (bus.Instr !== 32'h002081B3) begin n_bad++; $display("FAIL r_instr: got %h want 002081b3", bus.Instr); end
        n_vec++; if (bus.addr !== 32'h0) begin n_bad++; $display("FAIL r_addr: got %h want 0", bus.addr); end
    endtask

    task automatic test_back_to_back();
        instr_type_enum t_tab [5] = '{TYPE_I, TYPE_S, TYPE_B, TYPE_J, TYPE_U};
        logic [6:0]  op_tab  [5] = '{7'h13, 7'h23, 7'h63, 7'h6F, 7'h37};
        logic [4:0]  rd_tab  [5] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd5};
        logic [2:0]  f3_tab  [5] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        logic [4:0]  rs1_tab [5] = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
        logic [4:0]  rs2_tab [5] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
        logic [31:0] imm_tab [5] = '{32'd5, 32'd8, 32'hFFFF_FFFC, 32'h800, 32'h1234_5000};
        logic [31:0] exp_tab [5] = '{32'h00500093, 32'h0020A423, 32'hFE208EE3, 32'h001000EF, 32'h123452B7};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(t_tab[i], op_tab[i], rd_tab[i], f3_tab[i], rs1_tab[i], rs2_tab[i], 7'd0, imm_tab[i]);
            step();
            n_vec++; if (bus.Instr !== exp_tab[i]) begin n_bad++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, bus.Instr, exp_tab[i]); end
            n_vec++; if (bus.addr !== 32'(i * 4)) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.addr, i * 4); end
        end
        bus.in_valid = 1'b0;
        step();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin drive_legal(); step(); end
        n_vec++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", count); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        drive_legal();
        step();
        n_vec++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_5th_dropped: got %0d want 4", count); end
        bus.out_ready = 1'b1;
        step();
        n_vec++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_pop_count: got %0d want 3", count); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b0;
        step();
        n_vec++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_refill: got %0d want 4", count); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (bus.Instr !== exp_instr() || bus.addr !== exp_addr(BASE)) begin
                n_bad++; $display("FAIL full_order[%0d]: got %h@%h want %h@%h", i, bus.Instr, bus.addr, exp_instr(), exp_addr(BASE));
            end
            step();
        end
    endtask

    task automatic test_range();
        do_reset();
        drive(TYPE_I, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
        step();
        bus.in_valid = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        n_vec++; if (count !== 3'd0) begin n_bad++; $display("FAIL range_drop_count: got %0d want 0", count); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL range_err: got %b want 1", err); end
        step();
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL range_err_pulse: got %b want 0", err); end
        drive_legal();
        step();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.addr !== BASE) begin n_bad++; $display("FAIL range_addr_hold: got %h want %h", bus.addr, BASE); end
`else
        n_vec++; if (bus.Instr !== 32'h80000013) begin n_bad++; $display("FAIL trunc_instr: got %h want 80000013", bus.Instr); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL trunc_err: got %b want 0", err); end
`endif
        drive(instr_type_enum'(3'd6 + 3'($urandom_range(0, 1))), 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL unknown_err: got %b want 1", err); end
        n_vec++; if (count !== 3'(q.size())) begin n_bad++; $display("FAIL unknown_count: got %0d want %0d", count, q.size()); end
        step();
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL unknown_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_wrap_flush();
        do_reset();
        drive_legal(); step();
        drive_legal(); step();
        bus.in_valid = 1'b0;
        n_vec++; if (bus_w.addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got %h want fffffffc", bus_w.addr); end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        n_vec++; if (bus_w.addr !== 32'h0) begin n_bad++; $display("FAIL wrap_second: got %h want 0", bus_w.addr); end
        drive_legal(); step();
        flush = 1'b1; bus.out_ready = 1'b1; drive_legal();
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        step();
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_vec++; if (count_w !== 3'd0 || bus_w.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_empty: got count %0d valid %b want 0 0", count_w, bus_w.out_valid);
        end
        drive_legal(); step(); bus.in_valid = 1'b0;
        n_vec++; if (bus_w.addr !== BASE_W) begin n_bad++; $display("FAIL flush_addr: got %h want %h", bus_w.addr, BASE_W); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush         = ($urandom_range(0, 19) == 0);
            bus.out_ready = $urandom_range(0, 1);
            drive_legal();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) bus.imm = $urandom();
            if ($urandom_range(0, 15) == 0) bus.instr_type_enum_inst = instr_type_enum'(3'd6 + 3'($urandom_range(0, 1)));
            step();
            n_vec++; if (count !== 3'(q.size()) || count_w !== 3'(q.size())) begin
                n_bad++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d", i, count, count_w, q.size());
            end
            n_vec++; if (bus.Instr !== exp_instr() || bus.out_valid !== (q.size() != 0)) begin
                n_bad++; $display("FAIL rnd_head[%0d]: got %h v%b want %h", i, bus.Instr, bus.out_valid, exp_instr());
            end
            n_vec++; if (bus.addr !== exp_addr(BASE) || bus_w.addr !== exp_addr(BASE_W)) begin
                n_bad++; $display("FAIL rnd_addr[%0d]: got %h/%h want %h/%h", i, bus.addr, bus_w.addr, exp_addr(BASE), exp_addr(BASE_W));
            end
            n_vec++; if (err !== m_err || err_w !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err, m_err); end
            n_vec++; if (bus.in_ready !== ((q.size() != DEPTH) && !flush)) begin
                n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b", i, bus.in_ready);
            end
        end
        flush = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin drive_legal(); step(); end
        drive(instr_type_enum'(3'd7), 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        rst_n = 1'b0; flush = 1'b1;
        step();
        rst_n = 1'b1; flush = 1'b0; bus.in_valid = 1'b0;
        n_vec++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_empty: got count %0d valid %b want 0 0", count, bus.out_valid);
        end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_err: got %b want 0", err); end
        n_vec++; if (bus.addr !== BASE || bus.Instr !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got %h@%h want 0@%h", bus.Instr, bus.addr, BASE);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive(TYPE_R, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b0;
        test_reset();
        test_single_r();
        test_back_to_back();
        test_full();
        test_range();
        test_wrap_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, address tagged to the first word after reset or flush.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of FIFO and address counter.
REQ-006 in_valid / in_ready  input / output  1 / 1  field-side handshake; transfer when both high.
REQ-007 instr_type_enum_inst  input  instr_type_enum  format select: R/I/S/B/J/U.
REQ-008 opcode, rd, funct3, rs1, rs2, funct7  input  7/5/3/5/5/7  instruction fields.
REQ-009 imm  input  32  unscrambled immediate.
REQ-010 out_valid / out_ready  output / input  1 / 1  word-side handshake.
REQ-011 Instr, addr  output  32 / 32  encoded word and its byte address.
REQ-012 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 err  output  1  one-cycle pulse on a dropped input.

Function
REQ-014 Encoding SHALL be: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-015 Any other type value SHALL drop the input, pulse err, and leave the address unchanged.
REQ-016 in_ready SHALL equal (count != DEPTH) && !flush; registered state only, no pass-through from out_ready.
REQ-017 An accepted word SHALL be written to the FIFO at the edge of acceptance; out_valid SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-018 out_valid SHALL equal (count != 0); Instr/addr SHALL show the head entry and hold stable while out_valid && !out_ready.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-020 The address counter SHALL tag each pushed word, then add 4, wrapping modulo 2^32 (32'hFFFF_FFFC followed by 32'h0000_0000).
REQ-021 Dropped inputs SHALL NOT advance the address counter.
REQ-022 err SHALL assert in the cycle after the dropping acceptance, for exactly one cycle.
REQ-023 flush SHALL, at its edge, empty the FIFO, set the counter to BASE_ADDR, and ignore in_valid and out_ready that cycle.

Reset
REQ-024 rst_n low at an edge SHALL set count=0, out_valid=0, err=0, and the address counter to BASE_ADDR.
REQ-025 In-flight words SHALL be discarded on reset; Instr=0 and addr=BASE_ADDR while empty.
REQ-026 in_ready SHALL be 1 from the first edge with rst_n high.
REQ-027 Reset SHALL take priority over flush.

Configuration
REQ-028 With INSTR_ENC_RANGE_CHECK_EN defined, an immediate that does not fit its format SHALL be dropped as in REQ-015/021/022:
- I/S: imm not the sign-extension of imm[11:0];
- B: not the sign-extension of imm[12:0], or imm[0]=1;
- J: not the sign-extension of imm[20:0], or imm[0]=1;
- U: imm[11:0] != 0.
REQ-029 Without INSTR_ENC_RANGE_CHECK_EN, unused immediate bits SHALL be silently truncated; err SHALL pulse only for an unknown type.

Verification
REQ-030 Post-reset, push R add (opcode 0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0) -> next cycle out_valid=1, Instr=0x002081B3, addr=0x0.
REQ-031 Push, back-to-back, I addi x1,x0,5 / S sw x2,8(x1) / B beq x1,x2,imm=-4 / J jal x1,imm=0x800 / U lui x5,imm=0x12345000 -> Instr 0x00500093, 0x0020A423, 0xFE208EE3, 0x001000EF, 0x123452B7 at addr 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-032 Hold out_ready=0 with DEPTH=4 and push 4 words -> count=4, in_ready=0; a 5th in_valid is not accepted. Then one cycle with out_ready=1 and in_valid=1 -> first word popped, count=3, in_ready=1; next cycle accepted, count=4.
REQ-033 With the macro defined, push I imm=0x800 -> no word, err pulses 1 cycle, next valid word gets the unadvanced address. Without the macro -> word 0x80000013-form (imm[11:0]=0x800) enqueued, err=0.
REQ-034 BASE_ADDR=0xFFFFFFFC: push 2 words -> addr 0xFFFFFFFC then 0x0. Assert flush with 2 entries queued and in_valid=1 -> count=0, out_valid=0, next push addr=BASE_ADDR.
REQ-035 Assert rst_n=0 mid-stream with 3 entries queued -> next cycle count=0, out_valid=0, err=0.
